// File: rtl/button_event_ctrl_if.sv
// Button event bundle: debounced levels and run control in, sample strobe and
// one-hot event pulses out. The controller drives from master, the consumer from slave.
interface button_event_ctrl_if #(
  parameter int NUM_BUTTONS = 4,
  parameter int ID_W        = 2
);
  logic                   enable;
  logic [NUM_BUTTONS-1:0] btn_clean;
  logic                   sample_en;
  logic [NUM_BUTTONS-1:0] press;
  logic [NUM_BUTTONS-1:0] rel;
  logic [NUM_BUTTONS-1:0] hold;
  logic [NUM_BUTTONS-1:0] rpt;
  logic                   active;
  logic [ID_W-1:0]        active_id;

  modport master (
    input  enable, btn_clean,
    output sample_en, press, rel, hold, rpt, active, active_id
  );

  modport slave (
    output enable, btn_clean,
    input  sample_en, press, rel, hold, rpt, active, active_id
  );
endinterface

// File: rtl/button_event_ctrl.sv
// Shared debouncer sample strobe plus single-owner press/release/hold/repeat
// event generator for the front-panel buttons.
module button_event_ctrl #(
  parameter int NUM_BUTTONS  = 4,
  parameter int SAMPLE_DIV   = 100000,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic                clk,
  input  logic                reset,
  button_event_ctrl_if.master bus
);
  localparam int ID_W    = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int DW      = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DOWN, S_RPT, S_LOCK} state_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic hold;
    logic rpt;
  } ev_t;

  logic [DW-1:0]   div;
  logic            at_top;
  logic            tick;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, lim;
  logic [ID_W-1:0] id_q, id_n, win;
  logic            act_q, act_n, any;
  ev_t             ev_q, ev_n;

  // at_top mirrors (div == SAMPLE_DIV-1) so the strobe comes straight off a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= '0;
      at_top <= 1'b0;
    end else if (bus.enable) begin
      if (at_top) begin
        div    <= '0;
        at_top <= 1'b0;
      end else begin
        div    <= div + 1'b1;
        at_top <= (div == DW'(SAMPLE_DIV - 2));
      end
    end
  end

  assign tick          = at_top & bus.enable;
  assign bus.sample_en = tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      id_q  <= '0;
      act_q <= 1'b0;
      ev_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      id_q  <= id_n;
      act_q <= act_n;
      ev_q  <= ev_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    id_n    = id_q;
    act_n   = act_q;
    ev_n    = '0;
    any     = |bus.btn_clean;
    win     = '0;
    lim     = (state == S_DOWN) ? CW'(HOLD_TICKS - 1) : CW'(REPEAT_TICKS - 1);
    // descending scan: the lowest set index is the last one written
    for (int i = NUM_BUTTONS - 1; i >= 0; i--)
      if (bus.btn_clean[i]) win = ID_W'(i);
    if (tick) begin
      unique case (state)
        S_IDLE: if (any) begin
          id_n       = win;
          ev_n.press = 1'b1;
          act_n      = 1'b1;
          cnt_n      = '0;
          state_n    = S_DOWN;
        end
        S_DOWN, S_RPT: begin
          if (!bus.btn_clean[id_q]) begin
            ev_n.rel = 1'b1;
            act_n    = 1'b0;
            state_n  = any ? S_LOCK : S_IDLE;
          end else if (cnt == lim) begin
            cnt_n = '0;
            if (state == S_DOWN) begin
              ev_n.hold = 1'b1;
              state_n   = S_RPT;
            end else begin
              ev_n.rpt = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_LOCK: if (!any) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // one shared event code plus owner id keeps every event vector one-hot
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_dec
    wire sel = (id_q == ID_W'(i));
    assign bus.press[i] = ev_q.press & sel;
    assign bus.rel[i]   = ev_q.rel   & sel;
    assign bus.hold[i]  = ev_q.hold  & sel;
    assign bus.rpt[i]   = ev_q.rpt   & sel;
  end

  assign bus.active    = act_q;
  assign bus.active_id = id_q;
endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl; expected events are queued by the
// stimulus and matched by an independent monitor.
module tb_button_event_ctrl;
  localparam int NB  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_event_ctrl_if #(.NUM_BUTTONS(NB), .ID_W(IDW)) bus();

  button_event_ctrl #(
    .NUM_BUTTONS(NB), .SAMPLE_DIV(4), .HOLD_TICKS(5), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int          kind;   // 0 press, 1 release, 2 hold, 3 repeat
    logic [NB-1:0] vec;
    int          tick;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  int stick = 0, mtick = 0, cyc = 0;
  int press_cyc = 0, hold_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [NB-1:0] vec);
    exp_t e;
    e.kind = kind;
    e.vec  = vec;
    e.tick = stick;
    q.push_back(e);
  endtask

  // drive a level, let one sample tick consume it, return #1 after that edge
  task automatic tick_with(input logic [NB-1:0] v);
    bit seen;
    seen = 1'b0;
    bus.btn_clean = v;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.sample_en) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: no sample_en within 20 clks");
    end
    stick++;
    @(posedge clk);
    #1;
  endtask

  // monitor
  int          m_n, m_k;
  logic [NB-1:0] m_v;
  exp_t        m_e;
  always @(negedge clk) begin
    cyc++;
    m_n = 0; m_k = -1; m_v = '0;
    if (|bus.press) begin m_n++; m_k = 0; m_v = bus.press; end
    if (|bus.rel)   begin m_n++; m_k = 1; m_v = bus.rel;   end
    if (|bus.hold)  begin m_n++; m_k = 2; m_v = bus.hold;  end
    if (|bus.rpt)   begin m_n++; m_k = 3; m_v = bus.rpt;   end
    if (m_n > 1) begin
      chk("single_event", m_n, 1);
    end else if (m_n == 1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: kind=%0d vec=%b tick=%0d", m_k, m_v, mtick);
      end else begin
        m_e = q.pop_front();
        chk("ev_kind", m_k, m_e.kind);
        chk("ev_vec", m_v, m_e.vec);
        chk("ev_tick", mtick, m_e.tick);
        if (m_k == 0) press_cyc = cyc;
        if (m_k == 2) hold_cyc = cyc;
      end
    end
    if (bus.sample_en) mtick++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int hi, last;
  initial begin
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.btn_clean = '0;
    @(posedge clk); #1;
    chk("rst_sample_en", bus.sample_en, 0);
    chk("rst_events", {bus.press, bus.rel, bus.hold, bus.rpt}, 0);
    chk("rst_active", bus.active, 0);
    chk("rst_active_id", bus.active_id, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // divider: 40 clks idle
    hi = 0; last = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.sample_en) begin
        if (last < 0) chk("div_first", c, 3);
        else          chk("div_period", c - last, 4);
        last = c;
        hi++;
      end
    end
    chk("div_count", hi, 10);
    stick += hi;
    @(posedge clk); #1;

    // short press on button 2
    tick_with(4'b0100); expect_ev(0, 4'b0100);
    chk("sp_active", bus.active, 1);
    chk("sp_id", bus.active_id, 2);
    tick_with(4'b0100);
    tick_with(4'b0100);
    tick_with(4'b0000); expect_ev(1, 4'b0100);
    chk("sp_active_off", bus.active, 0);
    chk("sp_id_kept", bus.active_id, 2);

    // hold and repeat on button 0
    for (int r = 0; r < 15; r++) begin
      tick_with(4'b0001);
      if (r == 0) expect_ev(0, 4'b0001);
      if (r == 5) expect_ev(2, 4'b0001);
      if (r == 8 || r == 11 || r == 14) expect_ev(3, 4'b0001);
    end
    tick_with(4'b0000); expect_ev(1, 4'b0001);

    // arbitration and lockout
    tick_with(4'b1010); expect_ev(0, 4'b0010);
    chk("arb_id", bus.active_id, 1);
    tick_with(4'b1011);
    tick_with(4'b1011);
    chk("arb_no_preempt_id", bus.active_id, 1);
    chk("arb_no_preempt_act", bus.active, 1);
    tick_with(4'b1001); expect_ev(1, 4'b0010);
    chk("lock_active", bus.active, 0);
    tick_with(4'b1001);
    chk("lock_still_inactive", bus.active, 0);
    tick_with(4'b0000);
    tick_with(4'b1000); expect_ev(0, 4'b1000);
    chk("lock_new_owner_id", bus.active_id, 3);
    tick_with(4'b0000); expect_ev(1, 4'b1000);

    // pause mid-DOWN on button 1
    tick_with(4'b0010); expect_ev(0, 4'b0010);
    tick_with(4'b0010);
    tick_with(4'b0010);
    bus.enable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("pause_sample_en", bus.sample_en, 0);
    end
    @(posedge clk); #1;
    bus.enable = 1'b1;
    tick_with(4'b0010);
    tick_with(4'b0010);
    tick_with(4'b0010); expect_ev(2, 4'b0010);
    tick_with(4'b0000); expect_ev(1, 4'b0010);
    chk("pause_hold_delay", hold_cyc - press_cyc, 40);

    // reset mid-REPEAT on button 3, in the clk of a repeat pulse
    tick_with(4'b1000); expect_ev(0, 4'b1000);
    for (int r = 1; r < 8; r++) begin
      tick_with(4'b1000);
      if (r == 5) expect_ev(2, 4'b1000);
    end
    tick_with(4'b1000);
    chk("rst_pre_rpt", bus.rpt, 4'b1000);
    reset = 1'b1;
    #1;
    chk("rst_mid_events", {bus.press, bus.rel, bus.hold, bus.rpt}, 0);
    chk("rst_mid_active", bus.active, 0);
    chk("rst_mid_id", bus.active_id, 0);
    chk("rst_mid_sample_en", bus.sample_en, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    tick_with(4'b1000); expect_ev(0, 4'b1000);
    chk("rst_reacq_active", bus.active, 1);
    chk("rst_reacq_id", bus.active_id, 3);
    tick_with(4'b0000); expect_ev(1, 4'b1000);

    repeat (4) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
